// File: rtl/ksx_pkg.sv
// ksx_pkg: shared constants, state encoding and helpers for keystream_xor.
package ksx_pkg;

  // Width of the keystream word delivered by the LFSR.
  localparam int KS_W   = 16;

  // Width of the warm-up counter; covers WARMUP values 0..255.
  localparam int WCNT_W = 8;

  // Controller state encoding (kept as plain constants for legacy tools).
  typedef logic [1:0] ksx_state_t;
  localparam ksx_state_t ST_IDLE   = 2'd0;
  localparam ksx_state_t ST_WARMUP = 2'd1;
  localparam ksx_state_t ST_RUN    = 2'd2;

  // Largest value of the optional accepted-word statistics counter.
  localparam logic [31:0] STATS_MAX = 32'hFFFF_FFFF;

  // Saturating increment used by the statistics counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    return (value == STATS_MAX) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/ksx_skid_fifo.sv
// ksx_skid_fifo: two-entry valid/ready buffer. Two entries let the
// producer keep streaming at one word per cycle while the sink applies
// backpressure for a cycle, without a combinational ready path from
// out_ready to in_ready.
module ksx_skid_fifo #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] mem_q [2];
  logic              wr_ptr_q;
  logic              rd_ptr_q;
  logic [1:0]        count_q;
  logic [1:0]        count_d;
  logic              push;
  logic              pop;

  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign out_data  = mem_q[rd_ptr_q];
  assign count     = count_q;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Occupancy update: simultaneous push and pop leaves the count unchanged.
  always_comb begin
    // NOTE: assign a default first so every path drives count_d and no latch is inferred.
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Storage, pointers and occupancy; entries start at zero so out_data reads 0 after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the entries are reset because the head entry is visible on out_data; a plain
      // data RAM that is never read before being written would normally be left unreset.
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples
      // pre-edge values regardless of statement order.
      if (push) begin
        mem_q[wr_ptr_q] <= in_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/keystream_xor.sv
// keystream_xor: consumer stage for the 16-bit XNOR LFSR. Each accepted data
// word is XORed with the current keystream word and the LFSR is told to step
// (ks_adv) so the next accept sees the next word. After enable rises, WARMUP
// keystream words are discarded before data is accepted.
// Optional build macro KSX_STATS_EN adds the word_cnt output (saturating
// count of accepted words since the last start).
module keystream_xor
  import ksx_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int WARMUP = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [KS_W-1:0]   ks_in,
  output logic              ks_adv,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              running
`ifdef KSX_STATS_EN
  ,
  output logic [31:0]       word_cnt
`endif
);

  // Last warm-up count value and the state entered when enable rises.
  localparam int         WCNT_LAST_INT = (WARMUP > 0) ? (WARMUP - 1) : 0;
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WCNT_LAST_INT);
  localparam ksx_state_t START_STATE = (WARMUP > 0) ? ST_WARMUP : ST_RUN;

  ksx_state_t        state_q;
  ksx_state_t        state_d;
  logic [WCNT_W-1:0] wcnt_q;
  logic [WCNT_W-1:0] wcnt_d;
  logic              fifo_in_ready;
  logic              accept;
  logic              start;
  logic [DATA_W-1:0] push_data;
  logic [1:0]        fifo_count;

  // Input side only opens in RUN and only while the buffer has room.
  assign in_ready  = (state_q == ST_RUN) & fifo_in_ready;
  assign accept    = in_valid & in_ready;
  assign ks_adv    = (state_q == ST_WARMUP) | accept;
  assign running   = (state_q == ST_RUN);
  assign push_data = in_data ^ ks_in[DATA_W-1:0];
  assign start     = (state_q == ST_IDLE) & (state_d != ST_IDLE);

  // Controller next state and warm-up counter.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    unique case (state_q)
      ST_IDLE: begin
        wcnt_d = '0;
        if (enable) begin
          state_d = START_STATE;
        end
      end
      ST_WARMUP: begin
        // Each WARMUP cycle drives ks_adv; dropping enable keeps the advances already made.
        if (!enable) begin
          state_d = ST_IDLE;
          wcnt_d  = '0;
        end else if (wcnt_q == WCNT_LAST) begin
          state_d = ST_RUN;
          wcnt_d  = '0;
        end else begin
          wcnt_d = wcnt_q + WCNT_W'(1);
        end
      end
      ST_RUN: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        wcnt_d  = '0;
      end
    endcase
  end

  // Controller state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Output buffer; it keeps draining after the controller returns to IDLE.
  ksx_skid_fifo #(
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (accept),
    .in_ready  (fifo_in_ready),
    .in_data   (push_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (fifo_count)
  );

`ifdef KSX_STATS_EN
  logic [31:0] word_cnt_q;

  // Accepted-word counter, restarted on each IDLE exit and saturating at its maximum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt_q <= '0;
    end else if (start) begin
      word_cnt_q <= '0;
    end else if (accept) begin
      word_cnt_q <= sat_inc(word_cnt_q);
    end
  end

  assign word_cnt = word_cnt_q;
`endif

  // Buffer occupancy is only needed internally by the FIFO's own ready logic.
  logic unused_ok;
  assign unused_ok = ^{fifo_count, start};

endmodule

// File: tb/tb_keystream_xor.sv
// tb_keystream_xor: directed self-checking bench. Two instances are used: one
// with the default warm-up of 4 words and one with no warm-up. Each gets its
// keystream from its own cycle-accurate XNOR LFSR model (taps 16,15,13,4,
// seed 16'hACE1). Define KSX_STATS_EN to also exercise word_cnt.
module tb_keystream_xor;

  logic        clk;
  logic        rst_n;

  // Instance with WARMUP = 4.
  logic        enable;
  logic [15:0] ks_in;
  logic        ks_adv;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        running;

  // Instance with WARMUP = 0.
  logic        nw_enable;
  logic [15:0] nw_ks_in;
  logic        nw_ks_adv;
  logic        nw_in_valid;
  logic        nw_in_ready;
  logic [15:0] nw_in_data;
  logic        nw_out_valid;
  logic        nw_out_ready;
  logic [15:0] nw_out_data;
  logic        nw_running;
  logic        nw_hold_en;

`ifdef KSX_STATS_EN
  logic [31:0] word_cnt;
  logic [31:0] nw_word_cnt;
`endif

  logic [15:0] lfsr_q;
  logic [15:0] nw_lfsr_q;
  int          adv_cnt;
  int          nw_adv_cnt;

  int          n_checks;
  int          n_pass;
  int          adv0;
  int          sidx;
  int          k;
  int          got;
  int          n_acc;
  logic [15:0] seq [64];
  logic [15:0] dvec [8];
  logic [15:0] exp_word;
  logic [15:0] exp_q [$];

  keystream_xor #(
    .DATA_W (16),
    .WARMUP (4)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .ks_in     (ks_in),
    .ks_adv    (ks_adv),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .running   (running)
`ifdef KSX_STATS_EN
    ,
    .word_cnt  (word_cnt)
`endif
  );

  keystream_xor #(
    .DATA_W (16),
    .WARMUP (0)
  ) u_dut_nw (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (nw_enable),
    .ks_in     (nw_ks_in),
    .ks_adv    (nw_ks_adv),
    .in_valid  (nw_in_valid),
    .in_ready  (nw_in_ready),
    .in_data   (nw_in_data),
    .out_valid (nw_out_valid),
    .out_ready (nw_out_ready),
    .out_data  (nw_out_data),
    .running   (nw_running)
`ifdef KSX_STATS_EN
    ,
    .word_cnt  (nw_word_cnt)
`endif
  );

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ~(s[15] ^ s[14] ^ s[12] ^ s[3])};
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // LFSR models: step on the DUT's advance strobe, reset with the DUT.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q    <= 16'hACE1;
      nw_lfsr_q <= 16'hACE1;
    end else begin
      if (ks_adv)    lfsr_q    <= lfsr_next(lfsr_q);
      if (nw_ks_adv) nw_lfsr_q <= lfsr_next(nw_lfsr_q);
    end
  end

  assign ks_in    = lfsr_q;
  assign nw_ks_in = nw_hold_en ? 16'hA5A5 : nw_lfsr_q;

  // Advance-pulse counters.
  always @(posedge clk) begin
    if (rst_n && ks_adv)    adv_cnt    <= adv_cnt + 1;
    if (rst_n && nw_ks_adv) nw_adv_cnt <= nw_adv_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    n_checks++;
    if (got_v === exp_v) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got_v, exp_v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0; n_pass = 0; adv_cnt = 0; nw_adv_cnt = 0;
    rst_n = 1'b0;
    enable = 1'b0; in_valid = 1'b1; in_data = 16'h0000; out_ready = 1'b0;
    nw_enable = 1'b0; nw_in_valid = 1'b0; nw_in_data = 16'h0000; nw_out_ready = 1'b0;
    nw_hold_en = 1'b0;
    seq[0] = 16'hACE1;
    for (int i = 1; i < 64; i++) seq[i] = lfsr_next(seq[i-1]);
    dvec[0] = 16'h0001; dvec[1] = 16'h1234; dvec[2] = 16'hFFFF; dvec[3] = 16'h8000;
    dvec[4] = 16'hDEAD; dvec[5] = 16'hBEEF; dvec[6] = 16'h0F0F; dvec[7] = 16'h7E57;

    // Reset state (in_valid held high to show nothing is accepted).
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_running", running, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_ks_adv", ks_adv, 0);
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;

    // Basic XOR on the no-warm-up instance with a held keystream word.
    @(negedge clk);
    nw_hold_en = 1'b1; nw_enable = 1'b1;
    #1;
    check("t1_idle_running", nw_running, 0);
    check("t1_idle_ks_adv", nw_ks_adv, 0);
    @(negedge clk);
    check("t1_running", nw_running, 1);
    adv0 = nw_adv_cnt;
    nw_in_valid = 1'b1; nw_in_data = 16'hFFFF; nw_out_ready = 1'b1;
    #1;
    check("t1_in_ready", nw_in_ready, 1);
    check("t1_ks_adv", nw_ks_adv, 1);
    @(negedge clk);
    check("t1_out_valid", nw_out_valid, 1);
    check("t1_out_data", nw_out_data, 16'h5A5A);
    nw_in_valid = 1'b0;
    @(negedge clk);
    check("t1_out_valid_after", nw_out_valid, 0);
    check("t1_adv_pulses", nw_adv_cnt - adv0, 1);
    nw_enable = 1'b0; nw_hold_en = 1'b0;

    // Warm-up: four advances with input blocked, then RUN.
    @(negedge clk);
    enable = 1'b1; in_valid = 1'b1; in_data = 16'h1234; out_ready = 1'b1;
    adv0 = adv_cnt;
    #1;
    check("t2_idle_in_ready", in_ready, 0);
    check("t2_idle_ks_adv", ks_adv, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      check($sformatf("t2_wu%0d_ks_adv", i), ks_adv, 1);
      check($sformatf("t2_wu%0d_in_ready", i), in_ready, 0);
      check($sformatf("t2_wu%0d_running", i), running, 0);
    end
    @(negedge clk);
    #1;
    check("t2_running", running, 1);
    check("t2_in_ready", in_ready, 1);
    check("t2_adv_during_wu", adv_cnt - adv0, 4);
    sidx = 4;
    exp_word = 16'h1234 ^ seq[sidx];
    sidx++;
    @(negedge clk);
    in_valid = 1'b0;
    check("t2_out_valid", out_valid, 1);
    check("t2_out_data", out_data, exp_word);
    @(negedge clk);
    check("t2_out_valid_after", out_valid, 0);

    // Backpressure: eight words, sink stalled for the first six cycles.
    adv0 = adv_cnt; k = 0; got = 0;
    for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
      @(negedge clk);
      out_ready = (cyc >= 6);
      in_valid  = (k < 8);
      in_data   = (k < 8) ? dvec[k] : 16'h0000;
      #1;
      if (cyc == 2) check("t3_full_in_ready", in_ready, 0);
      if (cyc >= 1 && cyc < 6 && exp_q.size() > 0) begin
        check($sformatf("t3_stall%0d_valid", cyc), out_valid, 1);
        check($sformatf("t3_stall%0d_data", cyc), out_data, exp_q[0]);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() > 0) begin
          check($sformatf("t3_word%0d", got), out_data, exp_q.pop_front());
        end else begin
          check("t3_unexpected_output", 1, 0);
        end
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(dvec[k] ^ seq[sidx]);
        sidx++;
        k++;
      end
    end
    check("t3_words_out", got, 8);
    check("t3_adv_pulses", adv_cnt - adv0, 8);
    @(negedge clk);
    in_valid = 1'b0;

    // Stop with one word buffered.
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'hC3C3;
    adv0 = adv_cnt;
    #1;
    check("t4_in_ready", in_ready, 1);
    exp_word = 16'hC3C3 ^ seq[sidx];
    sidx++;
    @(negedge clk);
    in_valid = 1'b0; enable = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_data = 16'h0F0F;
    #1;
    check("t4_idle_in_ready", in_ready, 0);
    check("t4_idle_running", running, 0);
    check("t4_idle_ks_adv", ks_adv, 0);
    check("t4_buf_valid", out_valid, 1);
    check("t4_buf_data", out_data, exp_word);
    out_ready = 1'b1;
    @(negedge clk);
    #1;
    check("t4_drained", out_valid, 0);
    check("t4_idle_ks_adv2", ks_adv, 0);
    check("t4_adv_pulses", adv_cnt - adv0, 1);
    in_valid = 1'b0;

    // Reset with the buffer full, then restart.
    @(negedge clk);
    enable = 1'b1; out_ready = 1'b0;
    repeat (4) @(negedge clk);
    @(negedge clk);
    check("t5_running", running, 1);
    in_valid = 1'b1; in_data = 16'h1111;
    @(negedge clk);
    in_data = 16'h2222;
    @(negedge clk);
    in_valid = 1'b0;
    check("t5_full_in_ready", in_ready, 0);
    check("t5_full_out_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_out_valid", out_valid, 0);
    check("t5_rst_out_data", out_data, 0);
    check("t5_rst_running", running, 0);
    check("t5_rst_in_ready", in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b1; in_data = 16'h5555; out_ready = 1'b1;
    repeat (4) @(negedge clk);
    @(negedge clk);
    #1;
    check("t5_restart_running", running, 1);
    check("t5_restart_accept", in_ready, 1);
    exp_word = 16'h5555 ^ seq[4];
    @(negedge clk);
    in_valid = 1'b0;
    check("t5_restart_data", out_data, exp_word);

    // No-warm-up instance after reset: first output uses the seed word.
    @(negedge clk);
    nw_enable = 1'b1; nw_out_ready = 1'b1;
    @(negedge clk);
    nw_in_valid = 1'b1; nw_in_data = 16'h5555;
    @(negedge clk);
    nw_in_valid = 1'b0;
    check("t5_nw_seed_valid", nw_out_valid, 1);
    check("t5_nw_seed_data", nw_out_data, 16'hF9B4);

`ifdef KSX_STATS_EN
    // Statistics counter: ten accepts, then cleared on restart.
    check("t6_cnt_after_restart", word_cnt, 1);
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    check("t6_cnt_cleared", word_cnt, 0);
    repeat (3) @(negedge clk);
    n_acc = 0;
    for (int cyc = 0; cyc < 40 && n_acc < 10; cyc++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = 16'(cyc);
      #1;
      if (in_ready) n_acc++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("t6_accepts", n_acc, 10);
    check("t6_word_cnt", word_cnt, 10);
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    check("t6_word_cnt_toggle", word_cnt, 0);
`endif

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
